// File: rtl/ltc_frame_encoder.sv
// SMPTE LTC frame generator: BCD timecode counter, 80-bit frame assembly and
// biphase-mark line encoding driven by an external half-bit strobe.
module ltc_frame_encoder #(
  parameter int unsigned FPS = 25
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        half_bit_tick,
  input  logic        enable,
  input  logic        load,
  input  logic [25:0] load_tc,
  output logic        ltc_o,
  output logic        frame_start,
  output logic        busy,
  output logic [25:0] tc_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [5:0]  FrLast  = 6'(FPS - 1);
  // Sync word, bit 64 in the LSB: transmitted as 0011111111111101.
  localparam logic [15:0] SyncWord = 16'hBFFC;
  localparam logic [6:0]  LastBit  = 7'd79;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [6:0]  bit_idx_q, bit_idx_d;
  logic [79:0] frame_q, frame_d;
  logic [25:0] tc_q, tc_d;
  logic        ltc_q, ltc_d;
  logic        fs_q, fs_d;

  logic [79:0] frame_now;
  logic [25:0] tc_inc;
  logic        inc_tick;

  logic [3:0] fr_u, sc_u, mn_u, hr_u;
  logic [1:0] fr_t, hr_t;
  logic [2:0] sc_t, mn_t;
  logic [5:0] fr_val, hr_val, fr_n, hr_n;
  logic [6:0] sc_val, mn_val, sc_n, mn_n;
  logic       fr_wrap, sc_wrap, mn_wrap, hr_wrap;

  assign {hr_t, hr_u, mn_t, mn_u, sc_t, sc_u, fr_t, fr_u} = tc_q;

  assign fr_val = {4'd0, fr_t} * 6'd10 + {2'd0, fr_u};
  assign sc_val = {4'd0, sc_t} * 7'd10 + {3'd0, sc_u};
  assign mn_val = {4'd0, mn_t} * 7'd10 + {3'd0, mn_u};
  assign hr_val = {4'd0, hr_t} * 6'd10 + {2'd0, hr_u};

  // Terminal detection uses >= so out-of-range loaded values recover on the next carry.
  assign fr_wrap = fr_val >= FrLast;
  assign sc_wrap = sc_val >= 7'd59;
  assign mn_wrap = mn_val >= 7'd59;
  assign hr_wrap = hr_val >= 6'd23;

  assign fr_n = (fr_u >= 4'd9) ? {fr_t + 2'd1, 4'd0} : {fr_t, fr_u + 4'd1};
  assign sc_n = (sc_u >= 4'd9) ? {sc_t + 3'd1, 4'd0} : {sc_t, sc_u + 4'd1};
  assign mn_n = (mn_u >= 4'd9) ? {mn_t + 3'd1, 4'd0} : {mn_t, mn_u + 4'd1};
  assign hr_n = (hr_u >= 4'd9) ? {hr_t + 2'd1, 4'd0} : {hr_t, hr_u + 4'd1};

  always_comb begin
    tc_inc = tc_q;
    if (!fr_wrap) begin
      tc_inc[5:0] = fr_n;
    end else begin
      tc_inc[5:0] = 6'd0;
      if (!sc_wrap) begin
        tc_inc[12:6] = sc_n;
      end else begin
        tc_inc[12:6] = 7'd0;
        if (!mn_wrap) begin
          tc_inc[19:13] = mn_n;
        end else begin
          tc_inc[19:13] = 7'd0;
          tc_inc[25:20] = hr_wrap ? 6'd0 : hr_n;
        end
      end
    end
  end

  assign frame_now = {SyncWord, 6'd0, hr_t, 4'd0, hr_u, 5'd0, mn_t, 4'd0, mn_u,
                      5'd0, sc_t, 4'd0, sc_u, 6'd0, fr_t, 4'd0, fr_u};

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    ltc_d     = ltc_q;
    fs_d      = 1'b0;
    inc_tick  = 1'b0;
    if (half_bit_tick) begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_d   = StRun;
            ltc_d     = ~ltc_q;
            fs_d      = 1'b1;
            frame_d   = frame_now;
            phase_d   = 1'b1;
            bit_idx_d = 7'd0;
          end
        end
        StRun: begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            ltc_d = ~ltc_q;
            if (bit_idx_q == 7'd0) begin
              fs_d    = 1'b1;
              frame_d = frame_now;
            end
          end else begin
            if (frame_q[bit_idx_q]) ltc_d = ~ltc_q;
            if (bit_idx_q == LastBit) begin
              bit_idx_d = 7'd0;
              inc_tick  = 1'b1;
              if (!enable) state_d = StIdle;
            end else begin
              bit_idx_d = bit_idx_q + 7'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    // A load always overrides the end-of-frame increment.
    if (load)          tc_d = load_tc;
    else if (inc_tick) tc_d = tc_inc;
    else               tc_d = tc_q;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      phase_q   <= 1'b0;
      bit_idx_q <= 7'd0;
      frame_q   <= 80'd0;
      tc_q      <= 26'd0;
      ltc_q     <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      tc_q      <= tc_d;
      ltc_q     <= ltc_d;
      fs_q      <= fs_d;
    end
  end

  assign ltc_o       = ltc_q;
  assign frame_start = fs_q;
  assign busy        = (state_q == StRun);
  assign tc_o        = tc_q;

endmodule

// File: tb/tb_ltc_frame_encoder.sv
// Self-checking bench for ltc_frame_encoder: decodes the biphase line back into frames
// and compares them against a scoreboard of expected timecodes.
module tb_ltc_frame_encoder;

  localparam int FPS = 25;

  logic        clk_i;
  logic        reset_n;
  logic        half_bit_tick;
  logic        enable;
  logic        load;
  logic [25:0] load_tc;
  logic        ltc_o;
  logic        frame_start;
  logic        busy;
  logic [25:0] tc_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [25:0] sb_q[$];

  ltc_frame_encoder #(.FPS(FPS)) dut (
    .clk_i        (clk_i),
    .reset_n      (reset_n),
    .half_bit_tick(half_bit_tick),
    .enable       (enable),
    .load         (load),
    .load_tc      (load_tc),
    .ltc_o        (ltc_o),
    .frame_start  (frame_start),
    .busy         (busy),
    .tc_o         (tc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [25:0] make_tc(input int h, input int m, input int s, input int f);
    logic [1:0] ht;
    logic [2:0] mt, st;
    logic [1:0] ft;
    logic [3:0] hu, mu, su, fu;
    ht = 2'(h / 10); hu = 4'(h % 10);
    mt = 3'(m / 10); mu = 4'(m % 10);
    st = 3'(s / 10); su = 4'(s % 10);
    ft = 2'(f / 10); fu = 4'(f % 10);
    return {ht, hu, mt, mu, st, su, ft, fu};
  endfunction

  function automatic logic [25:0] tc_next(input logic [25:0] t);
    int f, s, m, h;
    f = int'(t[5:4]) * 10 + int'(t[3:0]);
    s = int'(t[12:10]) * 10 + int'(t[9:6]);
    m = int'(t[19:17]) * 10 + int'(t[16:13]);
    h = int'(t[25:24]) * 10 + int'(t[23:20]);
    if (f >= FPS - 1) begin
      f = 0;
      if (s >= 59) begin
        s = 0;
        if (m >= 59) begin
          m = 0;
          h = (h >= 23) ? 0 : h + 1;
        end else m++;
      end else s++;
    end else f++;
    return make_tc(h, m, s, f);
  endfunction

  function automatic logic [79:0] build_frame(input logic [25:0] t);
    logic [79:0] fr;
    logic [15:0] sync_tx;
    sync_tx = 16'b1011_1111_1111_1100; // bit i = i-th transmitted sync bit
    fr = '0;
    fr[3:0]   = t[3:0];
    fr[9:8]   = t[5:4];
    fr[19:16] = t[9:6];
    fr[26:24] = t[12:10];
    fr[35:32] = t[16:13];
    fr[42:40] = t[19:17];
    fr[51:48] = t[23:20];
    fr[57:56] = t[25:24];
    for (int i = 0; i < 16; i++) fr[64+i] = sync_tx[i];
    return fr;
  endfunction

  task automatic do_load(input logic [25:0] v);
    load = 1'b1;
    load_tc = v;
    @(negedge clk_i);
    load = 1'b0;
    n_tests++;
    if (tc_o !== v) begin
      n_fail++;
      $display("FAIL load_tc_o: got %h expected %h", tc_o, v);
    end
  endtask

  // Runs 160 half-bit ticks, decodes one frame and checks it against the scoreboard head.
  task automatic capture_frame(input string name, input int drop_at, input logic en_after,
                               input int load_at, input logic [25:0] load_val);
    logic [79:0] bits, exp_f;
    logic [25:0] exp_tc;
    logic prev, l1, lvl;
    int toggles, fs_cnt;
    bit fs_first, have_exp;
    bits = '0; toggles = 0; fs_cnt = 0; fs_first = 0; l1 = 1'b0;
    have_exp = (sb_q.size() != 0);
    exp_tc = have_exp ? sb_q.pop_front() : '0;
    exp_f = build_frame(exp_tc);
    prev = ltc_o;
    for (int k = 0; k < 160; k++) begin
      if (k == drop_at) enable = en_after;
      if (k == load_at) begin
        load = 1'b1;
        load_tc = load_val;
      end
      half_bit_tick = 1'b1;
      @(negedge clk_i);
      half_bit_tick = 1'b0;
      load = 1'b0;
      lvl = ltc_o;
      if (lvl !== prev) toggles++;
      if (frame_start === 1'b1) begin
        fs_cnt++;
        if (k == 0) fs_first = 1;
      end
      if (k % 2 == 0) l1 = lvl;
      else bits[k/2] = lvl ^ l1;
      prev = lvl;
      repeat ($urandom_range(0, 1)) @(negedge clk_i);
    end
    n_tests++;
    if (!have_exp) begin
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected a pending frame", name);
    end
    n_tests++;
    if (bits !== exp_f) begin
      n_fail++;
      $display("FAIL %s_bits: got %h expected %h (tc %h)", name, bits, exp_f, exp_tc);
    end
    n_tests++;
    if (bits[79:64] !== 16'hBFFC) begin
      n_fail++;
      $display("FAIL %s_sync: got %h expected %h", name, bits[79:64], 16'hBFFC);
    end
    n_tests++;
    if (toggles != 80 + $countones(exp_f)) begin
      n_fail++;
      $display("FAIL %s_toggles: got %0d expected %0d", name, toggles, 80 + $countones(exp_f));
    end
    n_tests++;
    if (fs_cnt != 1 || !fs_first) begin
      n_fail++;
      $display("FAIL %s_frame_start: got %0d pulses first=%0d expected 1 at tick 0",
               name, fs_cnt, fs_first);
    end
    n_tests++;
    if (busy !== en_after) begin
      n_fail++;
      $display("FAIL %s_busy_end: got %b expected %b", name, busy, en_after);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; half_bit_tick = 1'b0; enable = 1'b0; load = 1'b0; load_tc = '0;
    repeat (3) @(negedge clk_i);
    reset_n = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if ({ltc_o, frame_start, busy} !== 3'b000 || tc_o !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_values: got ltc=%b fs=%b busy=%b tc=%h expected all 0",
               ltc_o, frame_start, busy, tc_o);
    end
    for (int i = 0; i < 10; i++) begin
      half_bit_tick = 1'b1;
      @(negedge clk_i);
      half_bit_tick = 1'b0;
      n_tests++;
      if ({ltc_o, frame_start, busy} !== 3'b000 || tc_o !== 26'd0) begin
        n_fail++;
        $display("FAIL idle_tick%0d: got ltc=%b fs=%b busy=%b tc=%h expected all 0",
                 i, ltc_o, frame_start, busy, tc_o);
      end
    end
  endtask

  task automatic test_frame();
    do_load(make_tc(1, 2, 3, 4));
    sb_q.push_back(make_tc(1, 2, 3, 4));
    enable = 1'b1;
    capture_frame("frame", 1, 1'b0, -1, '0);
  endtask

  task automatic test_rollover();
    do_load(make_tc(23, 59, 59, 24));
    sb_q.push_back(make_tc(23, 59, 59, 24));
    sb_q.push_back(make_tc(0, 0, 0, 0));
    enable = 1'b1;
    capture_frame("roll_a", 1, 1'b1, -1, '0);
    capture_frame("roll_b", 1, 1'b0, -1, '0);
  endtask

  task automatic test_enable_drop();
    logic hold;
    do_load(make_tc(12, 34, 56, 7));
    sb_q.push_back(make_tc(12, 34, 56, 7));
    enable = 1'b1;
    capture_frame("drop", 50, 1'b0, -1, '0);
    n_tests++;
    if (tc_o !== tc_next(make_tc(12, 34, 56, 7))) begin
      n_fail++;
      $display("FAIL drop_tc_inc: got %h expected %h", tc_o, tc_next(make_tc(12, 34, 56, 7)));
    end
    hold = ltc_o;
    for (int i = 0; i < 10; i++) begin
      half_bit_tick = 1'b1;
      @(negedge clk_i);
      half_bit_tick = 1'b0;
      n_tests++;
      if (ltc_o !== hold || busy !== 1'b0 || frame_start !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_hold%0d: got ltc=%b busy=%b fs=%b expected ltc=%b busy=0 fs=0",
                 i, ltc_o, busy, frame_start, hold);
      end
    end
  endtask

  task automatic test_load_collision();
    do_load(make_tc(0, 0, 5, 0));
    sb_q.push_back(make_tc(0, 0, 5, 0));
    sb_q.push_back(make_tc(0, 0, 10, 0));
    sb_q.push_back(make_tc(0, 0, 10, 1));
    sb_q.push_back(make_tc(0, 0, 11, 0));
    enable = 1'b1;
    capture_frame("coll_a", 1, 1'b1, 159, make_tc(0, 0, 10, 0));
    capture_frame("coll_b", 1, 1'b1, -1, '0);
    capture_frame("coll_c", 1, 1'b1, 60, make_tc(0, 0, 10, 29));
    capture_frame("coll_d", 1, 1'b0, -1, '0);
  endtask

  task automatic test_back_to_back_reset();
    do_load(make_tc(7, 8, 9, 10));
    enable = 1'b1;
    for (int i = 0; i < 37; i++) begin
      half_bit_tick = 1'b1;
      @(negedge clk_i);
      half_bit_tick = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({ltc_o, frame_start, busy} !== 3'b000 || tc_o !== 26'd0) begin
      n_fail++;
      $display("FAIL async_reset: got ltc=%b fs=%b busy=%b tc=%h expected all 0",
               ltc_o, frame_start, busy, tc_o);
    end
    @(negedge clk_i);
    reset_n = 1'b1;
    @(negedge clk_i);
    sb_q.push_back(make_tc(0, 0, 0, 0));
    capture_frame("restart", 1, 1'b0, -1, '0);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_rollover();
    test_enable_drop();
    test_load_collision();
    test_back_to_back_reset();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
